armleo_mem_1rwm_port: RTL

//  Initiator-side controller for a byte-lane single-port memory (1 port, read-first, 1-cycle read

---
 rtl/armleo_mem_1rwm_port.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/armleo_mem_1rwm_port.sv
// Request-to-memory controller for a 1-port read-first byte-lane RAM, with optional zero-fill after reset.
// Latency: writes land at the accepting edge; read data is on rsp_* two cycles after the accept cycle.
// Backpressure: reads are held off while two responses are owed; writes are accepted whenever out of clear.

// Small generic in-order FIFO; push and pop may happen in the same cycle.
module armleo_mem_1rwm_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  output logic [W-1:0]                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [W-1:0]  entry [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  function automatic logic [AW-1:0] incr(input logic [AW-1:0] p);
    incr = (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Head of the queue is presented directly; zero after reset.
  assign rdata = entry[rptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= '0;
      end
    end else begin
      if (push) begin
        entry[wptr] <= wdata;
        wptr        <= incr(wptr);
      end
      if (pop) begin
        rptr <= incr(rptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module armleo_mem_1rwm_port #(
  parameter int DEPTH_LOG2     = 7,
  parameter int WIDTH          = 32,
  parameter int GRANULITY      = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          busy,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [DEPTH_LOG2-1:0]         req_address,
  input  logic [WIDTH/GRANULITY-1:0]    req_writeenable,
  input  logic [WIDTH-1:0]              req_writedata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [WIDTH-1:0]              rsp_readdata,
  output logic [DEPTH_LOG2-1:0]         mem_address,
  output logic                          mem_read,
  input  logic [WIDTH-1:0]              mem_readdata,
  output logic                          mem_write,
  output logic [WIDTH/GRANULITY-1:0]    mem_writeenable,
  output logic [WIDTH-1:0]              mem_writedata
);
  localparam int LANES = WIDTH / GRANULITY;

  if (WIDTH % GRANULITY != 0) begin : g_bad_granularity
    $fatal(1, "armleo_mem_1rwm_port: WIDTH must be a multiple of GRANULITY");
  end

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
  localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = '1;

  state_t                state, state_nxt;
  logic [DEPTH_LOG2-1:0] counter, counter_nxt;
  logic                  inflight;
  logic [1:0]            count;
  logic [2:0]            outstanding;
  logic                  pop;
  logic                  credit_ok;
  logic                  read_acc;
  logic                  write_acc;

  // A slot freed by this cycle's pop can be reused by this cycle's read.
  assign pop         = rsp_valid & rsp_ready;
  assign outstanding = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign credit_ok   = (outstanding < 3'd2);
  assign req_ready   = (state == ST_RUN) & (req_write | credit_ok);
  assign read_acc    = req_valid & req_ready & ~req_write;
  assign write_acc   = req_valid & req_ready & req_write;
  assign rsp_valid   = (count != 2'd0);

  // State register and clear-address counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RESET_STATE;
      counter <= '0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
    end
  end

  // Next state and memory-port drive: zero-fill sweep in CLEAR, request pass-through in RUN.
  always_comb begin
    state_nxt       = state;
    counter_nxt     = counter;
    busy            = 1'b0;
    mem_address     = req_address;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_writeenable = '0;
    mem_writedata   = req_writedata;
    case (state)
      ST_CLEAR: begin
        busy            = 1'b1;
        mem_address     = counter;
        mem_write       = 1'b1;
        mem_writeenable = {LANES{1'b1}};
        mem_writedata   = '0;
        counter_nxt     = counter + 1'b1;
        if (counter == LAST_ADDR) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        mem_read        = read_acc;
        mem_write       = write_acc;
        mem_writeenable = write_acc ? req_writeenable : '0;
      end
    endcase
  end

  // Marks the cycle in which the memory returns data for an accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= read_acc;
    end
  end

  armleo_mem_1rwm_fifo #(
    .W     (WIDTH),
    .DEPTH (2)
  ) u_rsp_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .wdata (mem_readdata),
    .pop   (pop),
    .rdata (rsp_readdata),
    .count (count)
  );
endmodule
